// File: rtl/comp_sched.sv
// comp_sched: round-robin scheduler sharing one compress/decompress engine
// between NUM_REQ requesters, one job in flight, with a response timeout.
module comp_sched #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [2*NUM_REQ-1:0]          req_cmd,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [1:0]                    rsp_code,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          busy,
   output logic [1:0]                    eng_command,
   output logic [DATA_WIDTH-1:0]         eng_data_in,
   output logic [DATA_WIDTH-1:0]         eng_compressed_in,
   input  logic [DATA_WIDTH-1:0]         eng_compressed_out,
   input  logic [DATA_WIDTH-1:0]         eng_decompressed_out,
   input  logic [1:0]                    eng_response
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
   localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [1:0] CMD_NOP    = 2'b00;
   localparam logic [1:0] CMD_COMP   = 2'b01;
   localparam logic [1:0] CMD_DECOMP = 2'b10;

   localparam logic [1:0] RC_OK  = 2'b01;
   localparam logic [1:0] RC_INV = 2'b10;
   localparam logic [1:0] RC_TMO = 2'b11;

   localparam logic [1:0] ER_PEND = 2'b00;
   localparam logic [1:0] ER_OK   = 2'b01;

   logic [1:0]            state_q, state_d;
   logic [IW-1:0]         ptr_q, ptr_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [1:0]            cmd_q, cmd_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [1:0]            code_q, code_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic [DATA_WIDTH-1:0] cin_q, cin_d;

   logic                  gnt_vld;
   logic [IW-1:0]         gnt_idx;
   logic [1:0]            gnt_cmd;
   logic [DATA_WIDTH-1:0] gnt_data;
   logic                  gnt_legal;
   logic                  hs;

   // first valid requester at or after ptr, wrapping
   always_comb begin
      int            j;
      logic [IW-1:0] jj;
      j       = 0;
      jj      = '0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         jj = IW'(j);
         if (!gnt_vld && req_valid[jj]) begin
            gnt_vld = 1'b1;
            gnt_idx = jj;
         end
      end
   end

   always_comb begin
      gnt_cmd  = CMD_NOP;
      gnt_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == IW'(i)) begin
            gnt_cmd  = req_cmd[2*i +: 2];
            gnt_data = req_data[DATA_WIDTH*i +: DATA_WIDTH];
         end
      end
   end

   assign gnt_legal = (gnt_cmd == CMD_COMP) || (gnt_cmd == CMD_DECOMP);

   always_comb begin
      req_ready = '0;
      if (!reset && (state_q == S_IDLE) && gnt_vld) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   assign hs = |req_ready;

   always_comb begin
      rsp_valid = '0;
      if (state_q == S_RESP) begin
         rsp_valid[idx_q] = 1'b1;
      end
   end

   assign busy              = (state_q != S_IDLE);
   assign eng_command       = (state_q == S_ISSUE) ? cmd_q : CMD_NOP;
   assign eng_data_in       = din_q;
   assign eng_compressed_in = cin_q;
   assign rsp_code          = code_q;
   assign rsp_data          = rdata_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      cmd_d   = cmd_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      rdata_d = rdata_q;
      din_d   = din_q;
      cin_d   = cin_q;
      unique case (state_q)
         S_IDLE: begin
            if (hs) begin
               idx_d = gnt_idx;
               cmd_d = gnt_cmd;
               ptr_d = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
               if (gnt_legal) begin
                  din_d   = (gnt_cmd == CMD_COMP) ? gnt_data : '0;
                  cin_d   = (gnt_cmd == CMD_DECOMP) ? gnt_data : '0;
                  state_d = S_ISSUE;
               end else begin
                  code_d  = RC_INV;
                  rdata_d = '0;
                  state_d = S_RESP;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (eng_response == ER_OK) begin
               code_d  = RC_OK;
               rdata_d = (cmd_q == CMD_COMP) ? eng_compressed_out
                                             : eng_decompressed_out;
               state_d = S_RESP;
            end else if (eng_response != ER_PEND) begin
               code_d  = RC_INV;
               rdata_d = '0;
               state_d = S_RESP;
            end else begin
               // saturating count: cannot wrap even if held in WAIT
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (cnt_d == CNT_MAX) begin
                  code_d  = RC_TMO;
                  rdata_d = '0;
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         cmd_q   <= CMD_NOP;
         cnt_q   <= '0;
         code_q  <= 2'b00;
         rdata_q <= '0;
         din_q   <= '0;
         cin_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         rdata_q <= rdata_d;
         din_q   <= din_d;
         cin_q   <= cin_d;
      end
   end

endmodule

// File: tb/tb_comp_sched.sv
// tb_comp_sched: vector table, hand sequences and a random run against a
// transaction-level model of the scheduler for comp_sched.
module tb_comp_sched;
   localparam int DW   = 8;
   localparam int NR   = 2;
   localparam int TO   = 16;
   localparam int CWID = 2 * NR;
   localparam int DWID = DW * NR;

   logic            clk;
   logic            reset;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [CWID-1:0] req_cmd;
   logic [DWID-1:0] req_data;
   logic [NR-1:0]   rsp_valid;
   logic [1:0]      rsp_code;
   logic [DW-1:0]   rsp_data;
   logic            busy;
   logic [1:0]      eng_command;
   logic [DW-1:0]   eng_data_in;
   logic [DW-1:0]   eng_compressed_in;
   logic [DW-1:0]   eng_compressed_out;
   logic [DW-1:0]   eng_decompressed_out;
   logic [1:0]      eng_response;

   int checks = 0;
   int errors = 0;

   comp_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .clk                  (clk),
      .reset                (reset),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_cmd              (req_cmd),
      .req_data             (req_data),
      .rsp_valid            (rsp_valid),
      .rsp_code             (rsp_code),
      .rsp_data             (rsp_data),
      .busy                 (busy),
      .eng_command          (eng_command),
      .eng_data_in          (eng_data_in),
      .eng_compressed_in    (eng_compressed_in),
      .eng_compressed_out   (eng_compressed_out),
      .eng_decompressed_out (eng_decompressed_out),
      .eng_response         (eng_response)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset        = 1'b1;
      req_valid    = '0;
      eng_response = 2'b00;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // one job from a single requester; engine answers at WAIT cycle dly
   task automatic do_job(input int r, input logic [1:0] c,
                         input logic [DW-1:0] d, input logic [1:0] resp,
                         input int dly, input logic [DW-1:0] eo,
                         output int lat, output logic [1:0] code,
                         output logic [DW-1:0] rd, output logic [NR-1:0] rv,
                         output int ncmd, output logic [DW-1:0] din,
                         output logic [DW-1:0] cin, output int bc);
      int  t;
      bit  done;
      lat  = -1; code = '0; rd = '0; rv = '0;
      ncmd = 0;  din  = '0; cin = '0; bc = 0;
      @(posedge clk); #1;
      req_valid    = NR'(1) << r;
      req_cmd      = CWID'(c) << (2 * r);
      req_data     = DWID'(d) << (DW * r);
      eng_response = 2'b00;
      @(negedge clk);
      t = 0;
      while (req_ready != (NR'(1) << r) && t < 50) begin
         @(posedge clk); #1;
         @(negedge clk);
         t++;
      end
      if (req_ready != (NR'(1) << r)) begin
         req_valid = '0;
         return;
      end
      done = 1'b0;
      for (int k = 1; k <= TO + 6 && !done; k++) begin
         @(posedge clk); #1;
         req_valid = '0;
         if (k == 2 + dly) begin
            eng_response         = resp;
            eng_compressed_out   = (c == 2'b01) ? eo : ~eo;
            eng_decompressed_out = (c == 2'b10) ? eo : ~eo;
         end else begin
            eng_response         = 2'b00;
            eng_compressed_out   = DW'($urandom);
            eng_decompressed_out = DW'($urandom);
         end
         @(negedge clk);
         if (busy) bc++;
         if (eng_command != 2'b00) begin
            ncmd++;
            din = eng_data_in;
            cin = eng_compressed_in;
         end
         if (rsp_valid != '0) begin
            lat  = k;
            rv   = rsp_valid;
            code = rsp_code;
            rd   = rsp_data;
            done = 1'b1;
         end
      end
      eng_response = 2'b00;
   endtask

   // grant rule: first pending requester at or after ptr, with wrap
   function automatic int rr_pick(input bit p[NR], input int ptr);
      for (int k = 0; k < NR; k++) begin
         if (p[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return -1;
   endfunction

   typedef struct {
      int          r;
      logic [1:0]  cmd;
      logic [7:0]  dat;
      logic [1:0]  resp;
      int          dly;
      logic [7:0]  eo;
      logic [1:0]  ecode;
      logic [7:0]  edat;
      int          elat;
      int          encmd;
      logic [7:0]  edin;
      logic [7:0]  ecin;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int              lat, ncmd, bc, g;
      logic [1:0]      code;
      logic [DW-1:0]   rd, din, cin;
      logic [NR-1:0]   rv, erv, erdy;
      int              gl[$], gcyc[$], rl[$], rcyc[$];
      int              overlap;
      bit              pend[NR];
      logic [1:0]      pcmd[NR];
      logic [DW-1:0]   pdat[NR];
      logic [NR-1:0]   rvv;
      logic [CWID-1:0] rcv;
      logic [DWID-1:0] rdv;
      int              mptr, t0, trsp, jreq, jdly;
      bit              active, jleg, ebusy;
      logic [1:0]      jcmd, jresp, ecode, er, ecmd;
      logic [DW-1:0]   jdat, edata, eco, edo;

      tbl[0] = '{0, 2'b01, 8'h5A, 2'b01, 0,  8'h3C, 2'b01, 8'h3C, 3,  1, 8'h5A, 8'h00};
      tbl[1] = '{0, 2'b01, 8'h5A, 2'b01, 1,  8'h3C, 2'b01, 8'h3C, 4,  1, 8'h5A, 8'h00};
      tbl[2] = '{1, 2'b10, 8'hA5, 2'b10, 0,  8'h77, 2'b10, 8'h00, 3,  1, 8'h00, 8'hA5};
      tbl[3] = '{1, 2'b10, 8'h33, 2'b01, 3,  8'hC4, 2'b01, 8'hC4, 6,  1, 8'h00, 8'h33};
      tbl[4] = '{0, 2'b11, 8'h11, 2'b01, 0,  8'h00, 2'b10, 8'h00, 1,  0, 8'h00, 8'h00};
      tbl[5] = '{0, 2'b00, 8'h22, 2'b01, 0,  8'h00, 2'b10, 8'h00, 1,  0, 8'h00, 8'h00};
      tbl[6] = '{1, 2'b01, 8'hF0, 2'b11, 5,  8'h12, 2'b10, 8'h00, 8,  1, 8'hF0, 8'h00};
      tbl[7] = '{0, 2'b10, 8'h81, 2'b01, 15, 8'h9E, 2'b01, 8'h9E, 18, 1, 8'h00, 8'h81};
      tbl[8] = '{0, 2'b01, 8'h44, 2'b01, 16, 8'h55, 2'b11, 8'h00, 18, 1, 8'h44, 8'h00};
      tbl[9] = '{1, 2'b01, 8'h0F, 2'b01, 0,  8'hE1, 2'b01, 8'hE1, 3,  1, 8'h0F, 8'h00};

      // reset values, with requests and engine activity present
      reset                = 1'b1;
      req_valid            = '1;
      req_cmd              = '1;
      req_data             = '1;
      eng_response         = 2'b01;
      eng_compressed_out   = '1;
      eng_decompressed_out = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_code", rsp_code, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_eng_command", eng_command, 0);
      chk("rst_eng_data_in", eng_data_in, 0);
      chk("rst_eng_comp_in", eng_compressed_in, 0);
      @(posedge clk); #1;
      reset        = 1'b0;
      req_valid    = '0;
      eng_response = 2'b00;

      for (int v = 0; v < 10; v++) begin
         do_job(tbl[v].r, tbl[v].cmd, tbl[v].dat, tbl[v].resp, tbl[v].dly,
                tbl[v].eo, lat, code, rd, rv, ncmd, din, cin, bc);
         erv = NR'(1) << tbl[v].r;
         chk($sformatf("tbl%0d_latency", v), lat, tbl[v].elat);
         chk($sformatf("tbl%0d_rsp_valid", v), rv, erv);
         chk($sformatf("tbl%0d_rsp_code", v), code, tbl[v].ecode);
         chk($sformatf("tbl%0d_rsp_data", v), rd, tbl[v].edat);
         chk($sformatf("tbl%0d_cmd_cycles", v), ncmd, tbl[v].encmd);
         chk($sformatf("tbl%0d_eng_data_in", v), din, tbl[v].edin);
         chk($sformatf("tbl%0d_eng_comp_in", v), cin, tbl[v].ecin);
         chk($sformatf("tbl%0d_busy_cycles", v), bc, tbl[v].elat);
      end

      // both requesters valid continuously, engine always answering ok
      do_reset();
      req_valid    = 2'b11;
      req_cmd      = {2'b01, 2'b01};
      req_data     = {8'h22, 8'h11};
      eng_response = 2'b01;
      overlap      = 0;
      for (int c = 0; c < 40 && gl.size() < 4; c++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            gl.push_back(req_ready == 2'b10 ? 1 : 0);
            gcyc.push_back(c);
         end
         if (rsp_valid != '0) begin
            rl.push_back(rsp_valid == 2'b10 ? 1 : 0);
            rcyc.push_back(c);
         end
         if ((req_ready != '0) && (rsp_valid != '0)) overlap++;
         @(posedge clk); #1;
      end
      req_valid = '0;
      chk("rr_grant_count", gl.size(), 4);
      for (int i = 0; i < gl.size(); i++) begin
         chk($sformatf("rr_grant%0d", i), gl[i], i % 2);
      end
      chk("rr_ready_rsp_overlap", overlap, 0);
      if (gcyc.size() >= 2 && rcyc.size() >= 1) begin
         chk("rr_req1_after_rsp0", (gcyc[1] > rcyc[0]) ? 1 : 0, 1);
         chk("rr_first_rsp_req", rl[0], 0);
      end
      repeat (6) @(posedge clk);

      // reset asserted while a job sits in WAIT
      #1;
      req_valid    = 2'b01;
      req_cmd      = {2'b00, 2'b01};
      req_data     = {8'h00, 8'h66};
      eng_response = 2'b00;
      @(negedge clk);
      chk("mw_grant", req_ready, 2'b01);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mw_busy_before", busy, 1);
      chk("mw_opnd_before", eng_data_in, 8'h66);
      @(posedge clk); #1;
      reset     = 1'b1;
      req_valid = 2'b11;
      @(negedge clk);
      chk("mw_req_ready", req_ready, 0);
      chk("mw_rsp_valid", rsp_valid, 0);
      chk("mw_rsp_code", rsp_code, 0);
      chk("mw_rsp_data", rsp_data, 0);
      chk("mw_busy", busy, 0);
      chk("mw_eng_command", eng_command, 0);
      chk("mw_eng_data_in", eng_data_in, 0);
      chk("mw_eng_comp_in", eng_compressed_in, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mw_rsp_after_release", rsp_valid, 0);
      chk("mw_req0_first", req_ready, 2'b01);
      @(posedge clk); #1;
      req_valid    = '0;
      eng_response = 2'b01;
      repeat (5) @(posedge clk);

      // random traffic against the transaction-level model
      do_reset();
      mptr   = 0;
      active = 1'b0;
      t0 = 0; trsp = 0; jreq = 0; jdly = 0; jleg = 1'b0;
      jcmd = '0; jresp = '0; ecode = '0; jdat = '0; edata = '0;
      for (int i = 0; i < NR; i++) begin
         pend[i] = 1'b0;
         pcmd[i] = '0;
         pdat[i] = '0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         rvv = '0; rcv = '0; rdv = '0;
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               pcmd[i] = 2'($urandom);
               pdat[i] = DW'($urandom);
            end
            rvv |= NR'(pend[i]) << i;
            rcv |= CWID'(pcmd[i]) << (2 * i);
            rdv |= DWID'(pdat[i]) << (DW * i);
         end
         req_valid = rvv;
         req_cmd   = rcv;
         req_data  = rdv;
         er  = 2'($urandom_range(0, 3));
         eco = DW'($urandom);
         edo = DW'($urandom);
         if (active && jleg && cyc >= t0 + 2) begin
            if (cyc < t0 + 2 + jdly) begin
               er = 2'b00;
            end else if (cyc == t0 + 2 + jdly) begin
               er = jresp;
               if (jresp == 2'b01 && jdly < TO)
                  edata = (jcmd == 2'b01) ? eco : edo;
            end
         end
         eng_response         = er;
         eng_compressed_out   = eco;
         eng_decompressed_out = edo;
         @(negedge clk);
         erv   = (active && cyc == trsp) ? (NR'(1) << jreq) : '0;
         ebusy = active;
         ecmd  = (active && jleg && cyc == t0 + 1) ? jcmd : 2'b00;
         g     = active ? -1 : rr_pick(pend, mptr);
         erdy  = (g >= 0) ? (NR'(1) << g) : '0;
         chk("rnd_rsp_valid", rsp_valid, erv);
         chk("rnd_busy", busy, ebusy);
         chk("rnd_eng_command", eng_command, ecmd);
         chk("rnd_req_ready", req_ready, erdy);
         if (erv != '0) begin
            chk("rnd_rsp_code", rsp_code, ecode);
            chk("rnd_rsp_data", rsp_data, edata);
         end
         if (ecmd != 2'b00) begin
            chk("rnd_eng_data_in", eng_data_in, (jcmd == 2'b01) ? jdat : '0);
            chk("rnd_eng_comp_in", eng_compressed_in,
                (jcmd == 2'b10) ? jdat : '0);
         end
         if (active && cyc == trsp) begin
            active = 1'b0;
         end else if (g >= 0) begin
            active  = 1'b1;
            t0      = cyc;
            jreq    = g;
            jcmd    = pcmd[g];
            jdat    = pdat[g];
            pend[g] = 1'b0;
            mptr    = (g + 1) % NR;
            edata   = '0;
            jleg    = (jcmd == 2'b01) || (jcmd == 2'b10);
            if (jleg) begin
               jdly  = $urandom_range(0, TO + 3);
               jresp = 2'($urandom_range(1, 3));
               if (jdly < TO) begin
                  trsp  = t0 + 3 + jdly;
                  ecode = (jresp == 2'b01) ? 2'b01 : 2'b10;
               end else begin
                  trsp  = t0 + TO + 2;
                  ecode = 2'b11;
               end
            end else begin
               trsp  = t0 + 1;
               ecode = 2'b10;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/comp_sched.md
# comp_sched

Round-robin command scheduler that shares one compression/decompression engine (`comp_if`-style datapath) between `NUM_REQ` requesters. Each requester submits one compress or decompress job through a valid/ready handshake. The scheduler forwards the job to the engine and waits for the engine response, with a timeout. It then returns the result and a status code to the originating requester. It sits between the client agents and the engine, and is the only block that drives engine `command`.

## Interface
- `DATA_WIDTH`, 8, width of data words (matches engine).
- `NUM_REQ`, 2, number of requesters (≥2).
- `TIMEOUT`, 16, maximum WAIT cycles before aborting a job (≥1).

- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in NUM_REQ: per-requester job valid.
- `req_ready` out NUM_REQ: one-hot grant/accept.
- `req_cmd` in 2*NUM_REQ: per-requester command, slice i = [2i+1:2i].
- `req_data` in DATA_WIDTH*NUM_REQ: per-requester operand.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle result pulse.
- `rsp_code` out 2: 01 ok, 10 invalid/illegal, 11 timeout.
- `rsp_data` out DATA_WIDTH: result word.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `eng_command` out 2: engine command (00 NOP, 01 compress, 10 decompress).
- `eng_data_in` out DATA_WIDTH: operand for compress.
- `eng_compressed_in` out DATA_WIDTH: operand for decompress.
- `eng_compressed_out` in DATA_WIDTH: engine compress result.
- `eng_decompressed_out` in DATA_WIDTH: engine decompress result.
- `eng_response` in 2: 00 pending, 01 valid, 10 invalid, 11 treated as invalid.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- **IDLE:**
  - The grant g is the first asserted `req_valid` at or after `ptr`, searching upward with wrap.
  - `req_ready[g]`=1, combinational. All other `req_ready` bits are 0. No valid requests means `req_ready`=0.
  - On handshake, latch the index, `req_cmd` slice and `req_data` slice. Then set `ptr`=g+1 mod NUM_REQ.
  - If the latched cmd is 01 or 10, go to ISSUE.
  - If the latched cmd is 00 or 11, go to RESPOND with code 10 and data 0. The engine is not touched.
- **ISSUE (1 cycle):**
  - `eng_command`=latched cmd.
  - The operand is driven on `eng_data_in` for cmd 01, or on `eng_compressed_in` for cmd 10. The other operand bus is 0.
  - Clear the timeout counter. Next state is WAIT.
- **WAIT:**
  - `eng_command`=00. Operand buses hold their values.
  - `eng_response`=01: capture `eng_compressed_out` (cmd 01) or `eng_decompressed_out` (cmd 10). Code 01, go to RESPOND.
  - `eng_response`=10 or 11: code 10, data 0, go to RESPOND.
  - `eng_response`=00: increment the counter. When the counter reaches TIMEOUT, code 11, data 0, go to RESPOND.
  - Counter width is $clog2(TIMEOUT+1). It never wraps.
- **RESPOND (1 cycle):**
  - `rsp_valid[idx]`=1. `rsp_code` and `rsp_data` are registered.
  - Next state is IDLE. A new grant is possible on the next cycle.
- `rsp_code` and `rsp_data` hold their last values between pulses. They are meaningful only while `rsp_valid` is nonzero.
- Only one job is outstanding at a time. There is no queuing.
- A requester must hold `req_valid`, `req_cmd` and `req_data` stable until ready.
- The engine's own reset is not driven by this block.

## Timing
- Reset values, asynchronously applied:
  - FSM=IDLE, `ptr`=0, timeout counter=0.
  - `req_ready`=0 (until reset deasserts), `rsp_valid`=0, `rsp_code`=00, `rsp_data`=0.
  - `busy`=0, `eng_command`=00, `eng_data_in`=0, `eng_compressed_in`=0.
- Handshake in cycle T:
  - T+1: ISSUE, with `eng_command` valid.
  - T+2 onward: `eng_response` sampled.
  - Response seen in cycle T+k (k≥2): `rsp_valid` at T+k+1.
- Minimum legal-job latency is 3 cycles. Illegal-command latency is 1 cycle (`rsp_valid` at T+1).
- Timeout case: `rsp_valid` at T+TIMEOUT+2.
- `eng_command` is nonzero for exactly one cycle per legal job.
- An `eng_response` that is nonzero outside WAIT is ignored.
- Reset asserted mid-job: the job is dropped with no `rsp_valid`, and all outputs return to reset values immediately.
- Several requests valid in the same cycle: exactly one grant, per `ptr`. Non-granted requesters wait.
- `rsp_valid` and `req_ready` are never high in the same cycle.

## Test plan
- **Reset then single compress.** Req0 cmd 01, data 0x5A; engine returns response 01, compressed_out 0x3C two cycles after command. Required: `eng_command`=01 for 1 cycle, `eng_data_in`=0x5A, `rsp_valid`=01, code 01, data 0x3C.
- **Round-robin fairness.** Req0 and req1 both valid continuously; engine responds 01 immediately. Required grant order 0,1,0,1, and every grant to req1 comes after a req0 response.
- **Decompress with engine invalid.** Req1 cmd 10, data 0xA5; `eng_response`=10. Required: `eng_compressed_in`=0xA5, `eng_data_in`=0, `rsp_valid`=10, code 10, data 0.
- **Timeout.** TIMEOUT=16; engine never responds. Required: code 11 at T+18, `busy` high T+1 through T+18, then the next request is granted.
- **Illegal command.** Req0 cmd 11. Required: `eng_command` stays 00, `rsp_valid`=01 at T+1, code 10.
- **Reset mid-WAIT.** Assert reset during WAIT. Required: all outputs 0 that cycle, no `rsp_valid`, and after release req1 beats req0 is false (`ptr`=0, so req0 is granted first).
